// File: rtl/idct_pkg.sv
// Shared IDCT definitions: block geometry, the sample type, the transpose
// buffer read-state enum and the row/column address swap helper.
package idct_pkg;

    localparam int BLK_N       = 8;
    localparam int BLK_SAMPLES = BLK_N * BLK_N;
    localparam int SAMPLE_W    = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [5:0]          idx_t;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } rd_state_t;

    // Output index m maps to row-major address (m%8)*8 + m/8.
    function automatic idx_t transpose_addr(input idx_t m);
        return {m[2:0], m[5:3]};
    endfunction

endpackage

// File: rtl/blk_transpose_tx_if.sv
// Handshake bundle of the transpose buffer: row-major input stream in,
// column-major output stream out with block first/last markers.
interface blk_transpose_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_first, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_first, out_last
    );
endinterface

// File: rtl/blk_bank_ram.sv
// One 64-entry sample bank: single write port, registered read port.
// Only the read register is reset; the storage array is not.
module blk_bank_ram #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [5:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [5:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:63];

    // Storage write; contents are don't-care until a block is written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register only loads on rd_en, so it holds its value while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/blk_transpose_tx.sv
// 8x8 transpose buffer between the two IDCT passes. Rows are written in
// row-major order and streamed out column-major with first/last markers.
// Build macro BLK_TX_PINGPONG_EN: two banks so one block can be written while
// the other is read; without it a single bank is written then read in turn.
module blk_transpose_tx #(
    parameter int DATA_W = 16,
    parameter int BLK_N  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    blk_transpose_tx_if.slave  bus
);
    import idct_pkg::*;

    localparam idx_t LAST_IDX = idx_t'(BLK_N * BLK_N - 1);
`ifdef BLK_TX_PINGPONG_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    logic [1:0]        full;
    logic              wb;
    logic              rb;
    idx_t              wr_idx;
    idx_t              rd_idx;
    rd_state_t         state;
    rd_state_t         state_nxt;
    logic              out_bank;
    logic              in_xfer;
    logic              wr_done;
    logic              out_xfer;
    logic              blk_end;
    logic              fetch;
    logic              fetch_bank;
    idx_t              fetch_idx;
    logic              other;
    logic              other_full;
    logic [DATA_W-1:0] rd_data [2];

    assign bus.in_ready = rst_n & ~full[wb];
    assign in_xfer      = bus.in_valid & bus.in_ready;
    assign wr_done      = in_xfer && (wr_idx == LAST_IDX);
    assign out_xfer     = bus.out_valid & bus.out_ready;
    assign blk_end      = (state == R_STREAM) && out_xfer && (rd_idx == LAST_IDX);

`ifdef BLK_TX_PINGPONG_EN
    // A block completing into the other bank on this same edge still counts,
    // so back-to-back blocks stream without a bubble.
    assign other      = ~rb;
    assign other_full = full[other] | (wr_done & (wb == other));
`else
    assign other      = rb;
    assign other_full = 1'b0;
`endif

    // Write side: fill the write bank, mark it full on the 64th sample.
    // The clear from the reader is applied first so a same-edge set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 2'b00;
            wb     <= 1'b0;
            wr_idx <= '0;
        end else begin
            if (blk_end) full[rb] <= 1'b0;
            if (in_xfer) begin
                if (wr_done) begin
                    wr_idx   <= '0;
                    full[wb] <= 1'b1;
`ifdef BLK_TX_PINGPONG_EN
                    wb       <= ~wb;
`endif
                end else begin
                    wr_idx <= idx_t'(wr_idx + idx_t'(1));
                end
            end
        end
    end

    // Read decode: decide whether a new sample is fetched into the output
    // register this edge, from which bank and index.
    always_comb begin
        fetch      = 1'b0;
        fetch_bank = rb;
        fetch_idx  = '0;
        state_nxt  = state;
        case (state)
            R_IDLE: begin
                if (full[rb]) begin
                    fetch     = 1'b1;
                    state_nxt = R_STREAM;
                end
            end
            R_STREAM: begin
                if (out_xfer) begin
                    if (rd_idx != LAST_IDX) begin
                        fetch     = 1'b1;
                        fetch_idx = idx_t'(rd_idx + idx_t'(1));
                    end else if (other_full) begin
                        fetch      = 1'b1;
                        fetch_bank = other;
                    end else begin
                        state_nxt = R_IDLE;
                    end
                end
            end
        endcase
    end

    // Read FSM with registered output flags; data comes from the bank's
    // read register, which only advances on a fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= R_IDLE;
            rb            <= 1'b0;
            rd_idx        <= '0;
            out_bank      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_first <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fetch) begin
                rd_idx        <= fetch_idx;
                out_bank      <= fetch_bank;
                bus.out_valid <= 1'b1;
                bus.out_first <= (fetch_idx == '0);
                bus.out_last  <= (fetch_idx == LAST_IDX);
            end else if (out_xfer) begin
                bus.out_valid <= 1'b0;
                bus.out_first <= 1'b0;
                bus.out_last  <= 1'b0;
            end
            if (blk_end) rb <= other;
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        blk_bank_ram #(.DATA_W(DATA_W)) u_ram (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (in_xfer && (wb == 1'(i))),
            .wr_addr (wr_idx),
            .wr_data (bus.in_data),
            .rd_en   (fetch && (fetch_bank == 1'(i))),
            .rd_addr (transpose_addr(fetch_idx)),
            .rd_data (rd_data[i])
        );
    end

    if (NUM_BANKS == 1) begin : g_pad
        assign rd_data[1] = '0;
    end

    assign bus.out_data = rd_data[out_bank];

endmodule

// File: tb/tb_blk_transpose_tx.sv
// Bench for blk_transpose_tx. Expected transposed blocks are queued when a
// block is fully sent and popped by a monitor on each output transfer.
// Covers both builds via BLK_TX_PINGPONG_EN.
module tb_blk_transpose_tx;
    import idct_pkg::*;

    typedef struct {
        sample_t data;
        logic    first;
        logic    last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    blk_transpose_tx_if #(.DATA_W(SAMPLE_W)) bus_if ();

    blk_transpose_tx #(.DATA_W(SAMPLE_W), .BLK_N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   seen = 0;
    int   last_xfer_edge = 0;
    exp_t sb[$];

    // Edge counter; an event seen at a negedge happens at edge cyc+1.
    always @(posedge clk) cyc++;

    // Scoreboard monitor: every pending output transfer is compared.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
            seen++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL sb_underflow got=%h first=%b last=%b want=none",
                         bus_if.out_data, bus_if.out_first, bus_if.out_last);
            end else begin
                e = sb.pop_front();
                if (bus_if.out_data !== e.data || bus_if.out_first !== e.first ||
                    bus_if.out_last !== e.last) begin
                    bad++;
                    $display("[TB] FAIL sb_data got=%h/%b/%b want=%h/%b/%b",
                             bus_if.out_data, bus_if.out_first, bus_if.out_last,
                             e.data, e.first, e.last);
                end
            end
            if (bus_if.out_last) last_xfer_edge = cyc + 1;
        end
    end

    task automatic push_block(input sample_t vals[64]);
        exp_t e;
        for (int m = 0; m < 64; m++) begin
            e.data  = vals[(m % 8) * 8 + m / 8];
            e.first = (m == 0);
            e.last  = (m == 63);
            sb.push_back(e);
        end
    endtask

    task automatic send_sample(input sample_t v, input int gap,
                               output int acc_edge, output int stalls);
        int waited;
        acc_edge = -1;
        repeat (gap) begin
            bus_if.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = v;
        waited = 0;
        @(negedge clk);
        while (!bus_if.in_ready && waited < 400) begin
            waited++;
            @(negedge clk);
        end
        stalls = waited;
        total++;
        if (!bus_if.in_ready) begin
            bad++;
            $display("[TB] FAIL in_timeout got=in_ready 0 want=1 sample=%h", v);
            bus_if.in_valid = 1'b0;
        end else begin
            acc_edge = cyc + 1;
            @(posedge clk); #1;
            bus_if.in_valid = 1'b0;
        end
    endtask

    task automatic send_block(input sample_t vals[64], input bit rnd,
                              output int first_edge, output int last_edge,
                              output int stalls);
        int gap;
        int e;
        int st;
        stalls = 0;
        first_edge = -1;
        last_edge = -1;
        for (int k = 0; k < 64; k++) begin
            gap = 0;
            if (rnd) while ($urandom_range(0, 1) == 0 && gap < 4) gap++;
            send_sample(vals[k], gap, e, st);
            stalls += st;
            if (k == 0)  first_edge = e;
            if (k == 63) last_edge = e;
        end
        push_block(vals);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || bus_if.out_valid) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (sb.size() != 0 || bus_if.out_valid) begin
            bad++;
            $display("[TB] FAIL drain_%s got=left %0d want=0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus_if.in_ready, bus_if.out_valid, bus_if.out_first, bus_if.out_last,
             bus_if.out_data} !== 20'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%b%b%b%b/%h want=0000/0000",
                     bus_if.in_ready, bus_if.out_valid, bus_if.out_first,
                     bus_if.out_last, bus_if.out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total++;
        if (bus_if.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_release_ready got=%b want=1", bus_if.in_ready);
        end
    endtask

    task automatic test_basic();
        sample_t v[64];
        int f, l, st;
        for (int k = 0; k < 64; k++) v[k] = sample_t'(k);
        bus_if.out_ready = 1'b1;
        send_block(v, 1'b0, f, l, st);
        total++;
        if (bus_if.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_early_valid got=%b want=0", bus_if.out_valid);
        end
        @(posedge clk); #1;
        total++;
        if ({bus_if.out_valid, bus_if.out_first, bus_if.out_last, bus_if.out_data} !==
            {1'b1, 1'b1, 1'b0, 16'h0000}) begin
            bad++;
            $display("[TB] FAIL basic_first_out got=%b%b%b/%h want=110/0000",
                     bus_if.out_valid, bus_if.out_first, bus_if.out_last, bus_if.out_data);
        end
        wait_drain(200, "basic");
    endtask

    task automatic test_stall();
        sample_t v[64];
        int f, l, st, base, n;
        for (int k = 0; k < 64; k++) v[k] = sample_t'(k);
        bus_if.out_ready = 1'b1;
        base = seen;
        send_block(v, 1'b0, f, l, st);
        n = 0;
        while (!(bus_if.out_valid && (seen - base) == 10) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("[TB] FAIL stall_reach_m10 got=seen %0d want=10", seen - base);
        end
        bus_if.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({bus_if.out_valid, bus_if.out_first, bus_if.out_last, bus_if.out_data} !==
                {1'b1, 1'b0, 1'b0, 16'd17}) begin
                bad++;
                $display("[TB] FAIL stall_hold got=%b%b%b/%0d want=100/17 cycle=%0d",
                         bus_if.out_valid, bus_if.out_first, bus_if.out_last,
                         bus_if.out_data, c);
            end
        end
        @(posedge clk); #1;
        bus_if.out_ready = 1'b1;
        wait_drain(200, "stall");
        total++;
        if (seen - base != 64) begin
            bad++;
            $display("[TB] FAIL stall_count got=%0d want=64", seen - base);
        end
    endtask

`ifdef BLK_TX_PINGPONG_EN
    task automatic test_back_to_back();
        sample_t va[64];
        sample_t vb[64];
        int fa, la, sta, fb, lb, stb, n, run;
        for (int k = 0; k < 64; k++) begin
            va[k] = sample_t'(k);
            vb[k] = sample_t'(100 + k);
        end
        bus_if.out_ready = 1'b1;
        run = 0;
        fork
            begin
                send_block(va, 1'b0, fa, la, sta);
                send_block(vb, 1'b0, fb, lb, stb);
            end
            begin
                n = 0;
                while (!bus_if.out_valid && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                while (bus_if.out_valid && run < 300) begin
                    run++;
                    @(negedge clk);
                end
            end
        join
        total++;
        if (sta + stb != 0) begin
            bad++;
            $display("[TB] FAIL b2b_in_ready_low got=%0d stalls want=0", sta + stb);
        end
        total++;
        if (fb != la + 1) begin
            bad++;
            $display("[TB] FAIL b2b_second_start got=edge %0d want=%0d", fb, la + 1);
        end
        total++;
        if (run != 128) begin
            bad++;
            $display("[TB] FAIL b2b_contiguous got=%0d want=128", run);
        end
        wait_drain(300, "b2b");
    endtask
`else
    task automatic test_back_to_back();
        sample_t va[64];
        sample_t vb[64];
        int fa, la, sta, fb, lb, stb;
        for (int k = 0; k < 64; k++) begin
            va[k] = sample_t'(k);
            vb[k] = sample_t'(200 + k);
        end
        bus_if.out_ready = 1'b1;
        send_block(va, 1'b0, fa, la, sta);
        total++;
        if (bus_if.in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_ready_blocked got=%b want=0", bus_if.in_ready);
        end
        send_block(vb, 1'b0, fb, lb, stb);
        total++;
        if (fb != last_xfer_edge + 1) begin
            bad++;
            $display("[TB] FAIL single_reopen got=edge %0d want=%0d", fb, last_xfer_edge + 1);
        end
        total++;
        if (fb != la + 66) begin
            bad++;
            $display("[TB] FAIL single_reopen_abs got=edge %0d want=%0d", fb, la + 66);
        end
        wait_drain(300, "single");
    endtask
`endif

    task automatic test_reset_mid();
        sample_t v[64];
        int e, st, f, l;
        bus_if.out_ready = 1'b1;
        for (int k = 0; k < 30; k++) send_sample(sample_t'(500 + k), 0, e, st);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus_if.in_ready, bus_if.out_valid, bus_if.out_first, bus_if.out_last,
             bus_if.out_data} !== 20'h0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs got=%b%b%b%b/%h want=0000/0000",
                     bus_if.in_ready, bus_if.out_valid, bus_if.out_first,
                     bus_if.out_last, bus_if.out_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        total++;
        if (bus_if.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_ready got=%b want=1", bus_if.in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (bus_if.out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midreset_stale_valid got=%b want=0", bus_if.out_valid);
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 64; k++) v[k] = sample_t'(k);
        send_block(v, 1'b0, f, l, st);
        wait_drain(200, "midreset");
    endtask

    task automatic test_random();
        sample_t v[64];
        int f, l, st, base, n;
        bit done;
        base = seen;
        done = 1'b0;
        fork
            begin
                for (int b = 0; b < 20; b++) begin
                    for (int k = 0; k < 64; k++) v[k] = sample_t'($urandom_range(0, 65535));
                    send_block(v, 1'b1, f, l, st);
                end
                done = 1'b1;
            end
            begin
                n = 0;
                while (!(done && sb.size() == 0) && n < 30000) begin
                    @(posedge clk); #1;
                    bus_if.out_ready = ($urandom_range(0, 1) == 1);
                    n++;
                end
                bus_if.out_ready = 1'b1;
            end
        join
        wait_drain(300, "random");
        total++;
        if (seen - base != 20 * 64) begin
            bad++;
            $display("[TB] FAIL random_count got=%0d want=%0d", seen - base, 20 * 64);
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blk_transpose_tx.md
BLK_TRANSPOSE_TX -- requirements
Module: blk_transpose_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter BLK_N, default 8, block edge; only 8 is supported, giving a 64-sample block.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_data, input, DATA_W, a row-major sample written by the upstream IDCT pass.
REQ-006 SHALL have port in_valid, input, 1, in_data is valid.
REQ-007 SHALL have port in_ready, output, 1, the block accepts in_data this cycle.
REQ-008 SHALL have port out_data, output, DATA_W, a column-major (transposed) sample for the second pass.
REQ-009 SHALL have port out_valid, output, 1, out_data is valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-011 SHALL have port out_first, output, 1, marks sample 0 of the block and is valid with out_valid.
REQ-012 SHALL have port out_last, output, 1, marks sample 63 of the block and is valid with out_valid.

Function
REQ-013 SHALL define a transfer as valid&&ready high at a rising clk edge, on either side.
REQ-014 SHALL write the k-th accepted input (k = 0..63) to bank[wb][k], with row = k/8 and col = k%8.
REQ-015 SHALL, on accepting k=63, set full[wb], toggle wb and reset the write index to 0.
REQ-016 SHALL derive in_ready from registered state only: in_ready = !full[wb].
REQ-017 SHALL read the m-th output (m = 0..63) from bank[rb][(m%8)*8 + m/8], which is the transpose.
REQ-018 SHALL implement the read FSM with states R_IDLE and R_STREAM:
- R_IDLE to R_STREAM when full[rb] is set.
- R_STREAM to R_IDLE on the m=63 transfer if the other bank is not full.
- Otherwise R_STREAM stays in R_STREAM with rb toggled, with no bubble.
REQ-019 SHALL assert out_valid exactly 1 cycle after the edge that sets full[rb] while the FSM is in R_IDLE.
REQ-020 SHALL sustain 1 sample per cycle while out_ready is high.
REQ-021 SHALL hold out_data, out_first and out_last stable while out_valid && !out_ready, and SHALL never drop out_valid before the transfer.
REQ-022 SHALL clear full[rb] on the m=63 transfer; the freed bank is writable from the next cycle.
REQ-023 SHALL, when a write completes into the bank being freed on the same edge, let the set take effect only after the clear (the registered in_ready already prevents this case).
REQ-024 SHALL pass data unmodified: no arithmetic and no width change.

Reset
REQ-025 SHALL on rst_n low force, asynchronously: in_ready=0 during reset; out_valid=0; out_first=0; out_last=0; out_data=0; full=2'b00; wb=0; rb=0; indices=0; FSM=R_IDLE.
REQ-026 SHALL discard any partial or unread block when reset is asserted mid-operation; in_ready=1 on the first cycle after reset release.
REQ-027 SHALL NOT require the bank storage to be reset.

Configuration
REQ-028 SHALL, with BLK_TX_PINGPONG_EN defined, use two banks and allow writing one block while the other is read.
REQ-029 SHALL, without BLK_TX_PINGPONG_EN, use one bank:
- wb and rb are fixed at 0.
- in_ready stays 0 from the k=63 accept until the m=63 transfer plus 1 cycle.

Structure
REQ-030 SHALL take from shared package idct_pkg: BLK_N and BLK_SAMPLES=64, the sample typedef, and the read-state enum.
REQ-031 SHALL contain one sub-module, blk_bank_ram: 64 x DATA_W, one write port, one registered read port; instantiated once per bank.

Verification
REQ-032 Write 0..63, out_ready=1 -> out_data sequence 0,8,16,...,56,1,9,...,63; out_first on 0; out_last on 63; out_valid rises 1 cycle after the k=63 accept.
REQ-033 Ping-pong, two blocks (0..63 then 100..163) back-to-back with out_ready=1 -> 128 contiguous out_valid cycles; the second block starts with 100,108; in_ready never low.
REQ-034 out_ready low for 5 cycles at m=10 -> out_data=17 held for 5 cycles; sequence otherwise intact.
REQ-035 Non-ping-pong build: send a second block immediately -> in_ready=0 until 1 cycle after out_last transfers; second block output correct.
REQ-036 Reset asserted after 30 writes -> all outputs 0 and full=0; after release a fresh 0..63 block produces the REQ-032 sequence.
REQ-037 Random in_valid/out_ready at 50% for 20 blocks -> scoreboard-matched transpose; no loss and no duplication.
